// File: rtl/bus_arbiter_if.sv
// Request/response bundle between the two pipeline ports, the arbiter and the
// shared downstream memory port.
interface bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int STRB_W = DATA_W / 8;

    logic [1:0]                    s_valid;
    logic [1:0][ADDR_W-1:0]        s_addr;
    logic [1:0]                    s_write;
    logic [1:0][2:0]               s_size;
    logic [1:0][STRB_W-1:0]        s_strobe;
    logic [1:0][DATA_W-1:0]        s_wdata;
    logic [1:0]                    s_addr_ok;
    logic [1:0]                    s_data_ok;
    logic [DATA_W-1:0]             s_rdata;

    logic                          m_valid;
    logic [ADDR_W-1:0]             m_addr;
    logic                          m_write;
    logic [2:0]                    m_size;
    logic [STRB_W-1:0]             m_strobe;
    logic [DATA_W-1:0]             m_wdata;
    logic                          m_ready;
    logic                          m_rvalid;
    logic [DATA_W-1:0]             m_rdata;

    // slave: the arbiter itself; master: requesters plus downstream memory
    modport slave (
        input  s_valid, s_addr, s_write, s_size, s_strobe, s_wdata,
        output s_addr_ok, s_data_ok, s_rdata,
        output m_valid, m_addr, m_write, m_size, m_strobe, m_wdata,
        input  m_ready, m_rvalid, m_rdata
    );

    modport master (
        output s_valid, s_addr, s_write, s_size, s_strobe, s_wdata,
        input  s_addr_ok, s_data_ok, s_rdata,
        input  m_valid, m_addr, m_write, m_size, m_strobe, m_wdata,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port single-outstanding arbiter sharing one downstream memory port
// between instruction fetch (port 0) and data access (port 1).
module bus_arbiter #(
    parameter int RR_MODE = 0,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic          i_clk,
    input  logic          i_reset,
    bus_arbiter_if.slave  bus,
    output logic [31:0]   o_cnt_port0,
    output logic [31:0]   o_cnt_port1
);
    localparam int STRB_W = DATA_W / 8;

    // state   | meaning
    // IDLE    | waiting for a request, grant decided combinationally
    // REQ     | latched request presented downstream until m_ready
    // RESP    | waiting for m_rvalid, response steered to granted port
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_grant;
    logic                r_rr_last;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [2:0]          r_size;
    logic [STRB_W-1:0]   r_strobe;
    logic [DATA_W-1:0]   r_wdata;
    logic [31:0]         r_cnt_port0;
    logic [31:0]         r_cnt_port1;

    logic                w_both;
    logic                w_winner;
    logic                w_take;
    logic                w_done;

    // Round-robin favours the port that lost the last contested grant.
    always_comb begin
        w_both = &bus.s_valid;
        if (w_both) begin
            w_winner = (RR_MODE != 0) ? ~r_rr_last : 1'b1;
        end else begin
            w_winner = bus.s_valid[1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_take        = 1'b0;
        w_done        = 1'b0;
        bus.s_addr_ok = 2'b00;
        bus.s_data_ok = 2'b00;
        bus.s_rdata   = '0;
        bus.m_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|bus.s_valid) begin
                    w_take                  = 1'b1;
                    bus.s_addr_ok[w_winner] = 1'b1;
                    w_state_nxt             = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.m_valid = 1'b1;
                if (bus.m_ready) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.m_rvalid) begin
                    w_done                 = 1'b1;
                    bus.s_data_ok[r_grant] = 1'b1;
                    bus.s_rdata            = bus.m_rdata;
                    w_state_nxt            = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grant     <= 1'b0;
            r_rr_last   <= 1'b0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= '0;
            r_strobe    <= '0;
            r_wdata     <= '0;
            r_cnt_port0 <= '0;
            r_cnt_port1 <= '0;
        end else begin
            if (w_take) begin
                r_grant  <= w_winner;
                r_addr   <= bus.s_addr[w_winner];
                r_write  <= bus.s_write[w_winner];
                r_size   <= bus.s_size[w_winner];
                r_strobe <= bus.s_strobe[w_winner];
                r_wdata  <= bus.s_wdata[w_winner];
                if (w_both) begin
                    r_rr_last <= w_winner;
                end
            end
            if (w_done) begin
                if (r_grant) begin
                    r_cnt_port1 <= r_cnt_port1 + 32'd1;
                end else begin
                    r_cnt_port0 <= r_cnt_port0 + 32'd1;
                end
            end
        end
    end

    assign bus.m_addr   = r_addr;
    assign bus.m_write  = r_write;
    assign bus.m_size   = r_size;
    assign bus.m_strobe = r_strobe;
    assign bus.m_wdata  = r_wdata;
    assign o_cnt_port0  = r_cnt_port0;
    assign o_cnt_port1  = r_cnt_port1;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: one fixed-priority and one round-robin instance
// driven with identical stimulus, each checked against its own model.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]        t_v;
    logic [1:0][63:0]  t_a;
    logic [1:0]        t_wr;
    logic [1:0][2:0]   t_sz;
    logic [1:0][7:0]   t_st;
    logic [1:0][63:0]  t_wd;
    logic              t_rdy, t_rv;
    logic [63:0]       t_rd;

    bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) if0 ();
    bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) if1 ();

    assign if0.s_valid = t_v;   assign if1.s_valid = t_v;
    assign if0.s_addr = t_a;    assign if1.s_addr = t_a;
    assign if0.s_write = t_wr;  assign if1.s_write = t_wr;
    assign if0.s_size = t_sz;   assign if1.s_size = t_sz;
    assign if0.s_strobe = t_st; assign if1.s_strobe = t_st;
    assign if0.s_wdata = t_wd;  assign if1.s_wdata = t_wd;
    assign if0.m_ready = t_rdy; assign if1.m_ready = t_rdy;
    assign if0.m_rvalid = t_rv; assign if1.m_rvalid = t_rv;
    assign if0.m_rdata = t_rd;  assign if1.m_rdata = t_rd;

    logic [31:0] cnt00, cnt01, cnt10, cnt11;

    bus_arbiter #(.RR_MODE(0), .ADDR_W(64), .DATA_W(64)) dut0 (
        .i_clk(clk), .i_reset(reset), .bus(if0),
        .o_cnt_port0(cnt00), .o_cnt_port1(cnt01));
    bus_arbiter #(.RR_MODE(1), .ADDR_W(64), .DATA_W(64)) dut1 (
        .i_clk(clk), .i_reset(reset), .bus(if1),
        .o_cnt_port0(cnt10), .o_cnt_port1(cnt11));

    logic [1:0]  d_aok[2], d_dok[2];
    logic        d_mv[2], d_mwr[2];
    logic [63:0] d_maddr[2], d_mwd[2], d_rdata[2];
    logic [2:0]  d_msz[2];
    logic [7:0]  d_mst[2];
    logic [31:0] d_cnt[2][2];

    assign d_aok[0] = if0.s_addr_ok;  assign d_aok[1] = if1.s_addr_ok;
    assign d_dok[0] = if0.s_data_ok;  assign d_dok[1] = if1.s_data_ok;
    assign d_mv[0] = if0.m_valid;     assign d_mv[1] = if1.m_valid;
    assign d_mwr[0] = if0.m_write;    assign d_mwr[1] = if1.m_write;
    assign d_maddr[0] = if0.m_addr;   assign d_maddr[1] = if1.m_addr;
    assign d_mwd[0] = if0.m_wdata;    assign d_mwd[1] = if1.m_wdata;
    assign d_rdata[0] = if0.s_rdata;  assign d_rdata[1] = if1.s_rdata;
    assign d_msz[0] = if0.m_size;     assign d_msz[1] = if1.m_size;
    assign d_mst[0] = if0.m_strobe;   assign d_mst[1] = if1.m_strobe;
    assign d_cnt[0][0] = cnt00;       assign d_cnt[0][1] = cnt01;
    assign d_cnt[1][0] = cnt10;       assign d_cnt[1][1] = cnt11;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: one outstanding transaction per instance.
    bit          mb_busy[2], mb_acc[2], mb_g[2], mb_loser[2];
    logic [63:0] mb_addr[2], mb_wd[2];
    logic        mb_wr[2];
    logic [2:0]  mb_sz[2];
    logic [7:0]  mb_st[2];
    logic [31:0] mb_cnt[2][2];

    function automatic bit pick(input int k, input logic [1:0] v);
        if (v == 2'b11) return (k == 0) ? 1'b1 : mb_loser[k];
        return v[1];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mb_busy[k] = 0; mb_acc[k] = 0; mb_g[k] = 0; mb_loser[k] = 1;
            mb_addr[k] = '0; mb_wd[k] = '0; mb_wr[k] = 0; mb_sz[k] = '0; mb_st[k] = '0;
            mb_cnt[k][0] = '0; mb_cnt[k][1] = '0;
        end
    endtask

    task automatic model_check_and_step(input int k);
        logic [1:0] e_aok, e_dok;
        bit w;
        w = pick(k, t_v);
        e_aok = (!mb_busy[k] && (t_v != 2'b00)) ? (2'b01 << w) : 2'b00;
        e_dok = (mb_busy[k] && mb_acc[k] && t_rv) ? (2'b01 << mb_g[k]) : 2'b00;
        chk($sformatf("d%0d_addr_ok", k), {62'd0, d_aok[k]}, {62'd0, e_aok});
        chk($sformatf("d%0d_data_ok", k), {62'd0, d_dok[k]}, {62'd0, e_dok});
        chk($sformatf("d%0d_m_valid", k), {63'd0, d_mv[k]}, {63'd0, mb_busy[k] && !mb_acc[k]});
        chk($sformatf("d%0d_m_addr", k), d_maddr[k], mb_addr[k]);
        chk($sformatf("d%0d_m_fields", k), {d_mwd[k][51:0], d_mwr[k], d_msz[k], d_mst[k]},
            {mb_wd[k][51:0], mb_wr[k], mb_sz[k], mb_st[k]});
        chk($sformatf("d%0d_cnt", k), {d_cnt[k][1], d_cnt[k][0]}, {mb_cnt[k][1], mb_cnt[k][0]});
        if (e_dok != 2'b00) chk($sformatf("d%0d_rdata", k), d_rdata[k], t_rd);
        if (!mb_busy[k]) begin
            if (t_v != 2'b00) begin
                if (t_v == 2'b11) mb_loser[k] = ~w;
                mb_busy[k] = 1; mb_acc[k] = 0; mb_g[k] = w;
                mb_addr[k] = t_a[w]; mb_wr[k] = t_wr[w]; mb_sz[k] = t_sz[w];
                mb_st[k] = t_st[w]; mb_wd[k] = t_wd[w];
            end
        end else if (!mb_acc[k]) begin
            if (t_rdy) mb_acc[k] = 1;
        end else if (t_rv) begin
            mb_cnt[k][mb_g[k]] = mb_cnt[k][mb_g[k]] + 32'd1;
            mb_busy[k] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        t_v = 2'b00; t_rdy = 0; t_rv = 0; t_rd = '0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [63:0] a0, a1;
        logic        rdy, rv;
        logic [63:0] rd;
        logic [1:0]  eaok, edok;
        logic        emv;
        logic [63:0] emaddr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{2'b01, 64'h8000_0000, 64'h0,   1'b1, 1'b0, 64'h0,         2'b01, 2'b00, 1'b0, 64'h0};
        tbl[1]  = '{2'b01, 64'h8000_0000, 64'h0,   1'b1, 1'b0, 64'h0,         2'b00, 2'b00, 1'b1, 64'h8000_0000};
        tbl[2]  = '{2'b01, 64'h8000_0000, 64'h0,   1'b0, 1'b1, 64'hDEAD_BEEF, 2'b00, 2'b01, 1'b0, 64'h8000_0000};
        tbl[3]  = '{2'b11, 64'h100,       64'h200, 1'b0, 1'b1, 64'h77,        2'b10, 2'b00, 1'b0, 64'h8000_0000};
        tbl[4]  = '{2'b11, 64'h100,       64'h999, 1'b0, 1'b1, 64'h77,        2'b00, 2'b00, 1'b1, 64'h200};
        tbl[5]  = '{2'b11, 64'h100,       64'h999, 1'b1, 1'b0, 64'h0,         2'b00, 2'b00, 1'b1, 64'h200};
        tbl[6]  = '{2'b11, 64'h100,       64'h999, 1'b0, 1'b1, 64'h1111,      2'b00, 2'b10, 1'b0, 64'h200};
        tbl[7]  = '{2'b01, 64'h100,       64'h0,   1'b1, 1'b0, 64'h0,         2'b01, 2'b00, 1'b0, 64'h200};
        tbl[8]  = '{2'b01, 64'h100,       64'h0,   1'b1, 1'b0, 64'h0,         2'b00, 2'b00, 1'b1, 64'h100};
        tbl[9]  = '{2'b01, 64'h100,       64'h0,   1'b0, 1'b0, 64'h0,         2'b00, 2'b00, 1'b0, 64'h100};
        tbl[10] = '{2'b01, 64'h100,       64'h0,   1'b0, 1'b1, 64'h2222,      2'b00, 2'b01, 1'b0, 64'h100};
        tbl[11] = '{2'b00, 64'h0,         64'h0,   1'b1, 1'b1, 64'h3333,      2'b00, 2'b00, 1'b0, 64'h100};

        t_a = '0; t_wr = '0; t_sz = {3'd3, 3'd3}; t_st = {8'hFF, 8'hFF}; t_wd = '0;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_d%0d_outputs", k),
                {58'd0, d_aok[k], d_dok[k], d_mv[k], d_mwr[k]}, 64'd0);
            chk($sformatf("rst_d%0d_m_addr", k), d_maddr[k], 64'd0);
            chk($sformatf("rst_d%0d_cnt", k), {d_cnt[k][1], d_cnt[k][0]}, 64'd0);
        end
        @(posedge clk); #1;

        // Directed fixed-priority sequence on the RR_MODE=0 instance
        for (int i = 0; i < 12; i++) begin
            t_v = tbl[i].v; t_a[0] = tbl[i].a0; t_a[1] = tbl[i].a1;
            t_rdy = tbl[i].rdy; t_rv = tbl[i].rv; t_rd = tbl[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d_addr_ok", i), {62'd0, d_aok[0]}, {62'd0, tbl[i].eaok});
            chk($sformatf("vec%0d_data_ok", i), {62'd0, d_dok[0]}, {62'd0, tbl[i].edok});
            chk($sformatf("vec%0d_m_valid", i), {63'd0, d_mv[0]}, {63'd0, tbl[i].emv});
            chk($sformatf("vec%0d_m_addr", i), d_maddr[0], tbl[i].emaddr);
            if (tbl[i].edok != 2'b00) chk($sformatf("vec%0d_rdata", i), d_rdata[0], tbl[i].rd);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("vec_cnt_d0", {cnt01, cnt00}, {32'd1, 32'd2});
        @(posedge clk); #1;

        // Reset while waiting for the response
        t_v = 2'b10; t_a[1] = 64'h300; t_rdy = 1; t_rv = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        t_v = 2'b00; t_rdy = 0; reset = 1;
        @(negedge clk);
        chk("resp_wait_m_valid", {63'd0, if0.m_valid}, 64'd0);
        chk("resp_wait_data_ok", {62'd0, if0.s_data_ok}, 64'd0);
        @(posedge clk); #1;
        reset = 0; t_rv = 1; t_rd = 64'h5555;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("midrst%0d_d%0d_outs", c, k),
                    {58'd0, d_aok[k], d_dok[k], d_mv[k], d_mwr[k]}, 64'd0);
                chk($sformatf("midrst%0d_d%0d_m_addr", c, k), d_maddr[k], 64'd0);
                chk($sformatf("midrst%0d_d%0d_cnt", c, k), {d_cnt[k][1], d_cnt[k][0]}, 64'd0);
            end
            @(posedge clk); #1;
        end

        // Permanent contention: 10 back-to-back transactions
        t_v = 2'b11; t_a[0] = 64'hA0; t_a[1] = 64'hA1; t_rdy = 1; t_rv = 1;
        for (int c = 0; c < 30; c++) begin
            logic [1:0] e_rr, e_fp;
            @(negedge clk);
            e_rr = ((c / 3) % 2 == 0) ? 2'b10 : 2'b01;
            e_fp = 2'b10;
            if (c % 3 == 0) begin
                chk($sformatf("cont%0d_rr_grant", c), {62'd0, d_aok[1]}, {62'd0, e_rr});
                chk($sformatf("cont%0d_fp_grant", c), {62'd0, d_aok[0]}, {62'd0, e_fp});
            end else if (c % 3 == 2) begin
                chk($sformatf("cont%0d_rr_done", c), {62'd0, d_dok[1]}, {62'd0, e_rr});
                chk($sformatf("cont%0d_fp_done", c), {62'd0, d_dok[0]}, {62'd0, e_fp});
            end else begin
                chk($sformatf("cont%0d_rr_quiet", c), {60'd0, d_aok[1], d_dok[1]}, 64'd0);
            end
            @(posedge clk); #1;
        end
        t_v = 2'b00;
        @(negedge clk);
        chk("cont_rr_cnt", {cnt11, cnt10}, {32'd5, 32'd5});
        chk("cont_fp_cnt", {cnt01, cnt00}, {32'd10, 32'd0});
        @(posedge clk); #1;

        // Counter wrap on port 1 of the fixed-priority instance
        force dut0.r_cnt_port1 = 32'hFFFF_FFFF;
        #1 release dut0.r_cnt_port1;
        t_v = 2'b10; t_rdy = 1; t_rv = 1;
        @(negedge clk);
        chk("wrap_preload", {32'd0, cnt01}, 64'hFFFF_FFFF);
        @(posedge clk); #1;
        t_v = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_cnt1", {cnt01, cnt00}, {32'd0, 32'd0});
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (t_v[p]) begin
                    if ($urandom_range(0, 15) == 0) t_v[p] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    t_v[p]  = 1'b1;
                    t_a[p]  = {$urandom, $urandom};
                    t_wr[p] = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    t_sz[p] = 3'($urandom_range(0, 3));
                    t_st[p] = 8'($urandom);
                    t_wd[p] = {$urandom, $urandom};
                end
                if ($urandom_range(0, 7) == 0) t_a[p] = {$urandom, $urandom};
            end
            t_rdy = 1'($urandom_range(0, 1));
            t_rv  = 1'($urandom_range(0, 1));
            t_rd  = {$urandom, $urandom};
            @(negedge clk);
            model_check_and_step(0);
            model_check_and_step(1);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-port, single-outstanding memory bus arbiter that shares one downstream memory port between the pipeline's instruction port (port 0, fetch) and data port (port 1, memory stage). It latches one request at a time, forwards it downstream, and steers the single response back to the granted requester. Per-port 32-bit transaction counters are kept for performance accounting.

## Interface
Parameters:
- RR_MODE, 0: 0 = fixed priority (port 1 wins), 1 = round-robin (port that lost the most recent contested grant wins)
- ADDR_W, 64: address width
- DATA_W, 64: data width (strobe width = DATA_W/8)

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high; clears all state on the posedge where it is sampled high
- s_valid  in  2  per-port request valid; held by requester until its s_data_ok
- s_addr  in  2×ADDR_W  per-port address
- s_write  in  2  per-port write enable (port 0 tied 0 by the core)
- s_size  in  2×3  per-port log2 byte size (0..3)
- s_strobe  in  2×8  per-port byte enables
- s_wdata  in  2×DATA_W  per-port write data
- s_addr_ok  out  2  one-hot pulse: request latched
- s_data_ok  out  2  one-hot pulse: response delivered
- s_rdata  out  DATA_W  read data (valid only with s_data_ok)
- m_valid  out  1  downstream request valid
- m_addr, m_write, m_size, m_strobe, m_wdata  out  ADDR_W/1/3/8/DATA_W  latched request fields
- m_ready  in  1  downstream accepted request
- m_rvalid  in  1  downstream response valid
- m_rdata  in  DATA_W  downstream read data
- cnt_port0, cnt_port1  out  32 each  completed-transaction counters

## Operation
- States: IDLE, REQ, RESP. Reset: state=IDLE, grant=0, rr_last=0, request registers 0, counters 0; all outputs 0.
- IDLE: if any s_valid, select winner: one valid → that port; both valid → port 1 if RR_MODE=0, else port ≠ rr_last. Same cycle: s_addr_ok[winner]=1 (combinational); at posedge latch winner's fields into request registers, grant←winner, rr_last←winner only if both were valid, state←REQ.
- REQ: m_valid=1, m_* driven from registers (stable regardless of s_* changes). m_ready=1 at posedge → RESP; else stay.
- RESP: m_valid=0. When m_rvalid=1: s_data_ok[grant]=1 and s_rdata=m_rdata same cycle (combinational); at posedge state←IDLE, cnt_port[grant]++.
- s_valid of the granted port is ignored in REQ/RESP; s_valid of the other port is held pending, never dropped.
- Writes follow the same path; m_rvalid still required to complete; s_rdata value don't-care.
- Counters wrap 0xFFFF_FFFF → 0.
- m_rvalid in IDLE/REQ: ignored, no s_data_ok. m_ready outside REQ: ignored.
- Any s_valid seen in IDLE is a new request; requesters deassert or change request the cycle after s_data_ok.

## Timing
- Minimum transaction: 3 cycles (IDLE grant, REQ with m_ready=1, RESP with m_rvalid=1); request-to-m_valid latency 1 cycle.
- Back-to-back: next grant evaluated in the IDLE cycle right after RESP; sustained rate 1 transaction / 3 cycles.
- s_addr_ok and s_data_ok are each exactly one cycle per transaction, never both in one cycle, never both ports at once.
- Reset mid-operation (REQ or RESP): next cycle IDLE, m_valid=0, no s_data_ok for the aborted transaction, counters 0; downstream is reset together.
- No combinational path from m_ready to any output; m_rvalid/m_rdata → s_data_ok/s_rdata is combinational.

## Test plan
- Single read port 0: s_valid=01, addr 0x8000_0000, m_ready=1 immediately, m_rvalid=1 one cycle later with 0xDEAD_BEEF → s_addr_ok=01 cycle 0, m_valid cycle 1, s_data_ok=01 with s_rdata=0xDEAD_BEEF cycle 2, cnt_port0=1.
- Contention RR_MODE=0: both valid for 4 transactions → port 1 always granted while valid; port 0 served only after port 1 deasserts; no request lost.
- Contention RR_MODE=1: both permanently valid → grants alternate 1,0,1,0; after 10 transactions cnt_port0=cnt_port1=5.
- Downstream stall: m_ready held 0 for 5 cycles in REQ while s_addr changes → m_valid and m_addr stay at latched value; completes after m_ready.
- Reset in RESP: assert reset with m_rvalid=0 → next cycle IDLE, all outputs 0, counters 0; late m_rvalid produces no s_data_ok.
- Counter wrap: preload via 2^32 transactions (or forced) → cnt_port1 0xFFFF_FFFF → 0 on next completion.
